// File: rtl/ttt_move_ctrl_if.sv
// Keypad/board bundle for the tic-tac-toe move controller.
// master = keypad/display side, slave = controller side.
interface ttt_move_ctrl_if;
    logic       key_valid;
    logic [3:0] key_num;
    logic [3:0] num;
    logic [1:0] pos1;
    logic [1:0] pos2;
    logic [1:0] pos3;
    logic [1:0] pos4;
    logic [1:0] pos5;
    logic [1:0] pos6;
    logic [1:0] pos7;
    logic [1:0] pos8;
    logic [1:0] pos9;
    logic       turn;
    logic [1:0] winner;
    logic       game_over;
    logic       move_err;

    modport master (
        output key_valid, key_num,
        input  num, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  turn, winner, game_over, move_err
    );

    modport slave (
        input  key_valid, key_num,
        output num, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output turn, winner, game_over, move_err
    );
endinterface

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: accepts keypad moves, keeps the board, judges win/draw.
// Optional TTT_AUTO_RESTART_EN: clear the game RESTART_CYCLES cycles after it ends.
module ttt_move_ctrl #(
    parameter int unsigned RESTART_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    ttt_move_ctrl_if.slave bus
);
    localparam int unsigned CELLS  = 9;
    localparam int unsigned LINES  = 8;
    localparam int unsigned NUM_W  = 4;
    localparam int unsigned CELL_W = 2;

    localparam logic [CELL_W-1:0] EMPTY  = 2'b00;
    localparam logic [CELL_W-1:0] MARK_X = 2'b01;
    localparam logic [CELL_W-1:0] MARK_O = 2'b10;
    localparam logic [CELL_W-1:0] DRAW   = 2'b11;

    // Bit i of each mask is cell i+1: rows, columns, diagonals.
    localparam logic [CELLS-1:0] LINE_MASK [LINES] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    typedef enum logic [1:0] {S_WAIT, S_CHECK, S_OVER} state_t;

    if (RESTART_CYCLES == 0) begin : g_bad_restart
        $error("RESTART_CYCLES must be at least 1");
    end

    state_t                         state_q, state_d;
    logic [CELLS-1:0][CELL_W-1:0]   board_q, board_d;
    logic [NUM_W-1:0]               num_q, num_d;
    logic                           turn_q, turn_d;
    logic [CELL_W-1:0]              winner_q, winner_d;
    logic                           err_q, err_d;
    logic                           game_over_q;
    logic                           key_valid_q;

    logic                           rise;
    logic [CELLS-1:0]               key_hot;
    logic [CELLS-1:0]               free_mask;
    logic [CELLS-1:0]               x_mask;
    logic [CELLS-1:0]               o_mask;
    logic                           key_ok;
    logic                           x_win;
    logic                           o_win;
    logic [CELL_W-1:0]              verdict;

`ifdef TTT_AUTO_RESTART_EN
    localparam int unsigned CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign rise = bus.key_valid & ~key_valid_q;

    // One-hot cell select and occupancy; key_num outside 1..9 selects nothing.
    always_comb begin : cell_decode
        key_hot   = '0;
        free_mask = '0;
        x_mask    = '0;
        o_mask    = '0;
        for (int i = 0; i < CELLS; i++) begin
            key_hot[i]   = (bus.key_num == NUM_W'(i + 1));
            free_mask[i] = (board_q[i] == EMPTY);
            x_mask[i]    = (board_q[i] == MARK_X);
            o_mask[i]    = (board_q[i] == MARK_O);
        end
        key_ok = |(key_hot & free_mask);
    end

    // Win takes priority over a full board.
    always_comb begin : judge
        x_win = 1'b0;
        o_win = 1'b0;
        for (int l = 0; l < LINES; l++) begin
            x_win = x_win | ((x_mask & LINE_MASK[l]) == LINE_MASK[l]);
            o_win = o_win | ((o_mask & LINE_MASK[l]) == LINE_MASK[l]);
        end
        if (x_win)            verdict = MARK_X;
        else if (o_win)       verdict = MARK_O;
        else if (~|free_mask) verdict = DRAW;
        else                  verdict = EMPTY;
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        board_d  = board_q;
        num_d    = num_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        err_d    = 1'b0;
`ifdef TTT_AUTO_RESTART_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (rise) begin
                    if (key_ok) begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (key_hot[i]) board_d[i] = turn_q ? MARK_O : MARK_X;
                        end
                        num_d   = bus.key_num;
                        state_d = S_CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                winner_d = verdict;
                if (verdict != EMPTY) begin
                    state_d = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_WAIT;
                end
            end
            S_OVER: begin
                err_d = rise;
`ifdef TTT_AUTO_RESTART_EN
                if (cnt_q == CNT_W'(RESTART_CYCLES - 1)) begin
                    board_d  = '0;
                    num_d    = '0;
                    turn_d   = 1'b0;
                    winner_d = EMPTY;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q     <= S_WAIT;
            board_q     <= '0;
            num_q       <= '0;
            turn_q      <= 1'b0;
            winner_q    <= EMPTY;
            err_q       <= 1'b0;
            game_over_q <= 1'b0;
            key_valid_q <= 1'b0;
`ifdef TTT_AUTO_RESTART_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            num_q       <= num_d;
            turn_q      <= turn_d;
            winner_q    <= winner_d;
            err_q       <= err_d;
            game_over_q <= (state_d == S_OVER);
            key_valid_q <= bus.key_valid;
`ifdef TTT_AUTO_RESTART_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.num       = num_q;
    assign bus.pos1      = board_q[0];
    assign bus.pos2      = board_q[1];
    assign bus.pos3      = board_q[2];
    assign bus.pos4      = board_q[3];
    assign bus.pos5      = board_q[4];
    assign bus.pos6      = board_q[5];
    assign bus.pos7      = board_q[6];
    assign bus.pos8      = board_q[7];
    assign bus.pos9      = board_q[8];
    assign bus.turn      = turn_q;
    assign bus.winner    = winner_q;
    assign bus.game_over = game_over_q;
    assign bus.move_err  = err_q;
endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: directed vector table, game-level reference model with
// random keypad traffic, and hand sequences for draw, held key, reset and restart.
module tb_ttt_move_ctrl;
    localparam int unsigned RC = 16;

    logic clk;
    logic reset_n;
    ttt_move_ctrl_if bus ();

    ttt_move_ctrl #(.RESTART_CYCLES(RC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- game-level reference model ----------------
    int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int mb [9];
    int m_num, m_win, m_cnt;
    bit m_turn, m_over, m_pend, m_err, m_prev;

    function automatic int judge();
        for (int l = 0; l < 8; l++)
            for (int p = 1; p <= 2; p++)
                if (mb[LINES[l][0]] == p && mb[LINES[l][1]] == p && mb[LINES[l][2]] == p)
                    return p;
        for (int i = 0; i < 9; i++) if (mb[i] == 0) return 0;
        return 3;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        m_num = 0; m_win = 0; m_cnt = 0;
        m_turn = 0; m_over = 0; m_pend = 0; m_err = 0; m_prev = 0;
    endfunction

    function automatic void model_step(input bit kv, input int kn);
        bit rise;
        int w;
        rise   = kv && !m_prev;
        m_prev = kv;
        m_err  = 0;
        if (m_pend) begin
            m_pend = 0;
            w = judge();
            if (w != 0) begin m_win = w; m_over = 1; m_cnt = 0; end
            else m_turn = !m_turn;
        end else if (m_over) begin
            m_err = rise;
`ifdef TTT_AUTO_RESTART_EN
            m_cnt++;
            if (m_cnt == int'(RC)) begin
                for (int i = 0; i < 9; i++) mb[i] = 0;
                m_num = 0; m_turn = 0; m_win = 0; m_over = 0; m_cnt = 0;
            end
`endif
        end else if (rise) begin
            if (kn >= 1 && kn <= 9 && mb[kn-1] == 0) begin
                mb[kn-1] = m_turn ? 2 : 1;
                m_num    = kn;
                m_pend   = 1;
            end else begin
                m_err = 1;
            end
        end
    endfunction

    function automatic logic [26:0] model_vec();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mb[i]);
        return {b, 4'(m_num), m_turn, 2'(m_win), m_over, m_err};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5, bus.pos4, bus.pos3,
                bus.pos2, bus.pos1, bus.num, bus.turn, bus.winner, bus.game_over, bus.move_err};
    endfunction

    task automatic check_vec(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = dut_vec();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got board=%h num=%0d turn=%b win=%b over=%b err=%b, expected board=%h num=%0d turn=%b win=%b over=%b err=%b",
                     name, act[26:9], act[8:5], act[4], act[3:2], act[1], act[0],
                     exp[26:9], exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge; reset is asserted and released before the next rise.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_vec("reset_state", model_vec());
        #1;
        reset_n = 1'b1;
    endtask

    task automatic cycle(input bit kv, input int kn);
        bus.key_valid = kv;
        bus.key_num   = 4'(kn);
        @(posedge clk);
        model_step(kv, kn);
        @(negedge clk);
        check_vec("model_cycle", model_vec());
    endtask

    task automatic play(input int kn);
        cycle(1, kn);
        cycle(0, kn);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          kv;
        logic [3:0]  kn;
        logic [17:0] board;
        logic [3:0]  num;
        logic        turn;
        logic [1:0]  win;
        logic        go;
        logic        err;
    } vec_t;

    vec_t vq [$];

    function automatic logic [17:0] bd(input int c1, input int c2, input int c3,
                                       input int c4, input int c5, input int c6,
                                       input int c7, input int c8, input int c9);
        return {2'(c9), 2'(c8), 2'(c7), 2'(c6), 2'(c5), 2'(c4), 2'(c3), 2'(c2), 2'(c1)};
    endfunction

    function automatic void add(input bit rst, input bit kv, input int kn, input logic [17:0] b,
                                input int num, input bit turn, input int win, input bit go, input bit err);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kn = 4'(kn); v.board = b; v.num = 4'(num);
        v.turn = turn; v.win = 2'(win); v.go = go; v.err = err;
        vq.push_back(v);
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        // X:1 O:4 X:2 O:5 X:3 wins, then a move in OVER is rejected.
        add(0,1,1, bd(1,0,0,0,0,0,0,0,0), 1,0,0,0,0);
        add(0,0,0, bd(1,0,0,0,0,0,0,0,0), 1,1,0,0,0);
        add(0,1,4, bd(1,0,0,2,0,0,0,0,0), 4,1,0,0,0);
        add(0,0,0, bd(1,0,0,2,0,0,0,0,0), 4,0,0,0,0);
        add(0,1,2, bd(1,1,0,2,0,0,0,0,0), 2,0,0,0,0);
        add(0,0,0, bd(1,1,0,2,0,0,0,0,0), 2,1,0,0,0);
        add(0,1,5, bd(1,1,0,2,2,0,0,0,0), 5,1,0,0,0);
        add(0,0,0, bd(1,1,0,2,2,0,0,0,0), 5,0,0,0,0);
        add(0,1,3, bd(1,1,1,2,2,0,0,0,0), 3,0,0,0,0);
        add(0,0,0, bd(1,1,1,2,2,0,0,0,0), 3,0,1,1,0);
        add(0,1,9, bd(1,1,1,2,2,0,0,0,0), 3,0,1,1,1);
        add(0,0,0, bd(1,1,1,2,2,0,0,0,0), 3,0,1,1,0);
        // Fresh game: first move, occupied cell, key 0, key 12, held key.
        add(1,0,0, bd(0,0,0,0,0,0,0,0,0), 0,0,0,0,0);
        add(0,1,5, bd(0,0,0,0,1,0,0,0,0), 5,0,0,0,0);
        add(0,0,0, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,0);
        add(0,1,5, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,1);
        add(0,0,0, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,0);
        add(0,1,0, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,1);
        add(0,0,0, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,0);
        add(0,1,12,bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,1);
        add(0,0,0, bd(0,0,0,0,1,0,0,0,0), 5,1,0,0,0);
        add(0,1,1, bd(2,0,0,0,1,0,0,0,0), 1,1,0,0,0);
        add(0,1,1, bd(2,0,0,0,1,0,0,0,0), 1,0,0,0,0);
        add(0,1,2, bd(2,0,0,0,1,0,0,0,0), 1,0,0,0,0);
        add(0,0,0, bd(2,0,0,0,1,0,0,0,0), 1,0,0,0,0);

        reset_n       = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_num   = 4'd0;
        @(negedge clk);
        do_reset();

        foreach (vq[i]) begin
            if (vq[i].rst) begin
                bus.key_valid = 1'b0;
                bus.key_num   = 4'd0;
                reset_n = 1'b0;
                #1;
                check_vec($sformatf("vec%0d", i),
                          {vq[i].board, vq[i].num, vq[i].turn, vq[i].win, vq[i].go, vq[i].err});
                #1;
                reset_n = 1'b1;
            end else begin
                bus.key_valid = vq[i].kv;
                bus.key_num   = vq[i].kn;
                @(posedge clk);
                @(negedge clk);
                check_vec($sformatf("vec%0d", i),
                          {vq[i].board, vq[i].num, vq[i].turn, vq[i].win, vq[i].go, vq[i].err});
            end
        end

        // Held key for 10 cycles gives one move, then finish as a draw.
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1, 1);
        begin
            int used;
            used = 0;
            used += (bus.pos1 != 0) + (bus.pos2 != 0) + (bus.pos3 != 0);
            used += (bus.pos4 != 0) + (bus.pos5 != 0) + (bus.pos6 != 0);
            used += (bus.pos7 != 0) + (bus.pos8 != 0) + (bus.pos9 != 0);
            check_val("held_key_cells", used, 1);
            check_val("held_key_pos1", int'(bus.pos1), 1);
        end
        cycle(0, 1);
        play(2); play(3); play(5); play(4); play(6); play(8); play(7); play(9);
        check_val("draw_winner", int'(bus.winner), 3);
        check_val("draw_game_over", int'(bus.game_over), 1);

`ifdef TTT_AUTO_RESTART_EN
        for (int k = 0; k < int'(RC) - 1; k++) cycle(0, 0);
        check_val("restart_not_early", int'(bus.game_over), 1);
        cycle(0, 0);
        check_val("restart_over_clear", int'(bus.game_over), 0);
        check_val("restart_pos9_clear", int'(bus.pos9), 0);
`else
        for (int k = 0; k < 20; k++) cycle(0, 0);
        check_val("over_terminal", int'(bus.game_over), 1);
        check_val("over_winner_held", int'(bus.winner), 3);
`endif

        // Reset in the CHECK cycle after X:3 drops that move.
        @(negedge clk);
        do_reset();
        play(1); play(2);
        cycle(1, 3);
        do_reset();
        play(7);
        check_val("after_reset_pos7", int'(bus.pos7), 1);
        check_val("after_reset_pos3", int'(bus.pos3), 0);

        // key_valid already high at reset release is a rise.
        bus.key_valid = 1'b1;
        bus.key_num   = 4'd6;
        do_reset();
        cycle(1, 6);
        check_val("rise_at_release_pos6", int'(bus.pos6), 1);
        cycle(0, 6);

        // Random keypad traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int kn;
            bit kv;
            if ($urandom_range(0, 199) == 0 || (m_over && $urandom_range(0, 29) == 0)) begin
                do_reset();
            end
            kv = ($urandom_range(0, 2) != 0);
            kn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            cycle(kv, kn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
